// File: rtl/note_lane_pkg.sv
// rtl/note_lane_pkg.sv - shared constants, state encoding and slot search for the note lane renderer
package note_lane_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_BG     = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Lowest set bit of v at or above lo; bit 5 of the result flags that one was found.
    function automatic logic [5:0] find_from(input logic [31:0] v, input int lo);
        logic [5:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (i >= lo && v[5'(i)]) begin
                r = {1'b1, 5'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/note_lane_renderer_square_scanner.sv
// rtl/note_lane_renderer_square_scanner.sv - dx/dy raster counter over one SQ_SIZE square
module square_scanner #(
    parameter int SQ_SIZE = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       advance,
    output logic [2:0] dx,
    output logic [2:0] dy,
    output logic       last_pixel
);

    localparam logic [2:0] LAST = 3'(SQ_SIZE - 1);

    logic [2:0] r_dx;
    logic [2:0] r_dy;
    logic       w_dx_last;
    logic       w_dy_last;

    assign w_dx_last  = (r_dx == LAST);
    assign w_dy_last  = (r_dy == LAST);
    assign last_pixel = w_dx_last && w_dy_last;
    assign dx         = r_dx;
    assign dy         = r_dy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (clear) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (advance) begin
            if (w_dx_last) begin
                r_dx <= '0;
                r_dy <= w_dy_last ? 3'd0 : r_dy + 3'd1;
            end else begin
                r_dx <= r_dx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/note_lane_renderer.sv
// rtl/note_lane_renderer.sv - draws one Taiko lane of note squares into the VGA frame buffer
// NOTE_LANE_ERASE_EN: when defined, empty slots are painted background instead of skipped.
module note_lane_renderer
    import note_lane_pkg::*;
#(
    parameter int NUM_SLOTS  = 10,
    parameter int SQ_SIZE    = 4,
    parameter int SLOT_PITCH = 8,
    parameter int X0         = 0,
    parameter int Y0         = 56
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [NUM_SLOTS-1:0] red_seq,
    input  logic [NUM_SLOTS-1:0] yellow_seq,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 done
);

`ifdef NOTE_LANE_ERASE_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif

    localparam logic [31:0] SLOT_MASK = 32'((64'd1 << NUM_SLOTS) - 64'd1);

    if (NUM_SLOTS < 1 || NUM_SLOTS > 32 || SQ_SIZE < 1 || SQ_SIZE > 8 || SLOT_PITCH < SQ_SIZE
        || X0 + (NUM_SLOTS - 1) * SLOT_PITCH + SQ_SIZE > SCREEN_W || Y0 + SQ_SIZE > SCREEN_H) begin : g_bad_geometry
        $error("note_lane_renderer: lane geometry does not fit the 160x120 frame");
    end

    state_e      r_state;
    logic [31:0] r_red;
    logic [31:0] r_yel;
    logic [4:0]  r_slot;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_plot;
    logic        r_busy;
    logic        r_done;

    logic        w_start;
    logic [2:0]  w_dx;
    logic [2:0]  w_dy;
    logic        w_last_pixel;
    logic [31:0] w_occ_in;
    logic [31:0] w_occ;
    logic [5:0]  w_first;
    logic [5:0]  w_next;
    logic [7:0]  w_x;
    logic [6:0]  w_y;
    logic [2:0]  w_colour;

    assign w_start = (r_state == ST_IDLE) && start;

    square_scanner #(.SQ_SIZE(SQ_SIZE)) u_scanner (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (w_start),
        .advance    (r_state == ST_DRAW),
        .dx         (w_dx),
        .dy         (w_dy),
        .last_pixel (w_last_pixel)
    );

    // With erase on every slot counts as occupied, so the search never skips.
    assign w_occ_in = ERASE_EN ? SLOT_MASK : (32'(red_seq) | 32'(yellow_seq));
    assign w_occ    = ERASE_EN ? SLOT_MASK : (r_red | r_yel);
    assign w_first  = find_from(w_occ_in, 0);
    assign w_next   = find_from(w_occ, int'(r_slot) + 1);

    assign w_x      = 8'(X0 + SLOT_PITCH * int'(r_slot) + int'(w_dx));
    assign w_y      = 7'(Y0 + int'(w_dy));
    assign w_colour = r_red[r_slot] ? COL_RED : (r_yel[r_slot] ? COL_YELLOW : COL_BG);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_red    <= '0;
            r_yel    <= '0;
            r_slot   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_red   <= 32'(red_seq);
                        r_yel   <= 32'(yellow_seq);
                        r_slot  <= w_first[4:0];
                        r_state <= w_first[5] ? ST_DRAW : ST_DONE;
                    end
                end
                ST_DRAW: begin
                    r_plot   <= 1'b1;
                    r_busy   <= 1'b1;
                    r_x      <= w_x;
                    r_y      <= w_y;
                    r_colour <= w_colour;
                    if (w_last_pixel) begin
                        if (w_next[5]) begin
                            r_slot <= w_next[4:0];
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_note_lane_renderer.sv
// tb/tb_note_lane_renderer.sv - randomized scoreboard bench for note_lane_renderer
module tb_note_lane_renderer;

`ifdef NOTE_LANE_ERASE_EN
    localparam bit ERASE = 1'b1;
`else
    localparam bit ERASE = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk;
    logic       resetn;
    logic       a_start, b_start;
    logic [9:0] a_red, a_yel;
    logic [3:0] b_red, b_yel;
    logic [7:0] a_x, b_x;
    logic [6:0] a_y, b_y;
    logic [2:0] a_col, b_col;
    logic       a_plot, a_busy, a_done, b_plot, b_busy, b_done;

    int checks = 0;
    int failures = 0;

    pix_t exp_q[$];
    pix_t obs_q[$];
    int   obs_first, obs_last, obs_done, obs_ndone, obs_busy_bad;
    logic [31:0] chain_red, chain_yel;

    note_lane_renderer u_a (
        .clk(clk), .resetn(resetn), .start(a_start), .red_seq(a_red), .yellow_seq(a_yel),
        .x(a_x), .y(a_y), .colour(a_col), .plot(a_plot), .busy(a_busy), .done(a_done)
    );

    note_lane_renderer #(.NUM_SLOTS(4), .SQ_SIZE(8), .SLOT_PITCH(10), .X0(100)) u_b (
        .clk(clk), .resetn(resetn), .start(b_start), .red_seq(b_red), .yellow_seq(b_yel),
        .x(b_x), .y(b_y), .colour(b_col), .plot(b_plot), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: list every pixel the lane should produce, slot by slot, row by row.
    task automatic build_exp(input logic [31:0] red, input logic [31:0] yel, input int n,
                             input int sq, input int pitch, input int x0);
        pix_t p;
        logic [2:0] col;
        exp_q.delete();
        for (int s = 0; s < n; s++) begin
            col = red[s] ? 3'b100 : (yel[s] ? 3'b110 : 3'b000);
            if (red[s] || yel[s] || ERASE) begin
                for (int dy = 0; dy < sq; dy++) begin
                    for (int dx = 0; dx < sq; dx++) begin
                        p.x = 8'(x0 + s * pitch + dx);
                        p.y = 7'(56 + dy);
                        p.c = col;
                        exp_q.push_back(p);
                    end
                end
            end
        end
    endtask

    task automatic drive(input bit which, input logic [31:0] red, input logic [31:0] yel, input logic st);
        if (which) begin
            b_red = red[3:0]; b_yel = yel[3:0]; b_start = st;
        end else begin
            a_red = red[9:0]; a_yel = yel[9:0]; a_start = st;
        end
    endtask

    // Pulses start (unless already set up), then records every cycle until done; inputs are scrambled after the latch edge.
    task automatic run(input bit which, input logic [31:0] red, input logic [31:0] yel,
                       input int poke_c, input bit skip_start, input bit chain);
        pix_t p;
        logic pl, bz, dn;
        obs_q.delete();
        obs_first = -1; obs_last = -1; obs_done = -1; obs_ndone = 0; obs_busy_bad = 0;
        if (!skip_start) begin
            @(negedge clk);
            drive(which, red, yel, 1'b1);
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            pl  = which ? b_plot : a_plot;
            bz  = which ? b_busy : a_busy;
            dn  = which ? b_done : a_done;
            p.x = which ? b_x : a_x;
            p.y = which ? b_y : a_y;
            p.c = which ? b_col : a_col;
            if (pl) begin
                obs_q.push_back(p);
                if (obs_first < 0) obs_first = c;
                obs_last = c;
            end
            if (bz !== pl) obs_busy_bad++;
            if (dn) begin
                obs_ndone++;
                if (obs_done < 0) obs_done = c;
            end
            if (obs_done >= 0 && (chain || c > obs_done)) begin
                if (chain) drive(which, chain_red, chain_yel, 1'b1);
                else drive(which, $urandom, $urandom, 1'b0);
                break;
            end
            drive(which, $urandom, $urandom, c == poke_c);
        end
    endtask

    function automatic int pix_diff();
        int d;
        d = 0;
        if (obs_q.size() != exp_q.size()) return -1;
        foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    function automatic int timing_err();
        int e;
        int n;
        e = 0;
        n = obs_q.size();
        if (obs_done != n + 1) e |= 1;
        if (n > 0 && (obs_first != 1 || obs_last != n)) e |= 2;
        if (obs_ndone != 1) e |= 4;
        if (obs_busy_bad != 0) e |= 8;
        return e;
    endfunction

    task automatic test_reset();
        checks++; if (a_x !== 8'd0) begin failures++; $display("FAIL reset_x: got %0d want 0", a_x); end
        checks++; if (a_y !== 7'd0) begin failures++; $display("FAIL reset_y: got %0d want 0", a_y); end
        checks++; if (a_col !== 3'd0) begin failures++; $display("FAIL reset_colour: got %b want 000", a_col); end
        checks++; if ({a_plot, a_busy, a_done} !== 3'b000) begin failures++; $display("FAIL reset_flags: plot/busy/done=%b want 000", {a_plot, a_busy, a_done}); end
        checks++; if ({b_x, b_y, b_col, b_plot, b_busy, b_done} !== '0) begin failures++; $display("FAIL reset_b: outputs nonzero x=%0d y=%0d", b_x, b_y); end
    endtask

    task automatic test_lane_pattern();
        pix_t want_first, want_last;
        int d, t;
        build_exp(32'b0110101010, 32'd0, 10, 4, 8, 0);
        run(1'b0, 32'b0110101010, 32'd0, -1, 1'b0, 1'b0);
        want_first = ERASE ? {8'd0, 7'd56, 3'b000} : {8'd8, 7'd56, 3'b100};
        want_last  = ERASE ? {8'd75, 7'd59, 3'b000} : {8'd67, 7'd59, 3'b100};
        checks++; if (obs_q.size() !== (ERASE ? 160 : 80)) begin failures++; $display("FAIL pattern_count: got %0d want %0d", obs_q.size(), ERASE ? 160 : 80); end
        d = pix_diff();
        checks++; if (d !== 0) begin failures++; $display("FAIL pattern_pixels: %0d mismatches (-1 = length) want 0", d); end
        checks++; if (obs_q.size() == 0 || obs_q[0] !== want_first) begin failures++; $display("FAIL pattern_first: got %h want %h", obs_q.size() ? obs_q[0] : pix_t'(0), want_first); end
        checks++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== want_last) begin failures++; $display("FAIL pattern_last: got %h want %h", obs_q.size() ? obs_q[obs_q.size()-1] : pix_t'(0), want_last); end
        t = timing_err();
        checks++; if (t !== 0) begin failures++; $display("FAIL pattern_timing: code %0d done_c=%0d want 0", t, obs_done); end
    endtask

    task automatic test_priority();
        int c3, c4, d;
        c3 = -1; c4 = -1;
        build_exp(32'h08, 32'h18, 10, 4, 8, 0);
        run(1'b0, 32'h08, 32'h18, -1, 1'b0, 1'b0);
        foreach (obs_q[i]) begin
            if (obs_q[i].x == 8'd24 && obs_q[i].y == 7'd56) c3 = int'(obs_q[i].c);
            if (obs_q[i].x == 8'd35 && obs_q[i].y == 7'd59) c4 = int'(obs_q[i].c);
        end
        checks++; if (c3 !== 4) begin failures++; $display("FAIL priority_slot3: colour %0d want 4", c3); end
        checks++; if (c4 !== 6) begin failures++; $display("FAIL priority_slot4: colour %0d want 6", c4); end
        d = pix_diff();
        checks++; if (d !== 0 || timing_err() !== 0) begin failures++; $display("FAIL priority_model: diff %0d timing %0d want 0 0", d, timing_err()); end
    endtask

    task automatic test_empty();
        build_exp(32'd0, 32'd0, 10, 4, 8, 0);
        run(1'b0, 32'd0, 32'd0, -1, 1'b0, 1'b0);
        checks++; if (obs_done !== (ERASE ? 161 : 1)) begin failures++; $display("FAIL empty_done: at cycle %0d want %0d", obs_done, ERASE ? 161 : 1); end
        checks++; if (obs_q.size() !== (ERASE ? 160 : 0) || obs_busy_bad !== 0) begin failures++; $display("FAIL empty_plot: plots %0d busy_err %0d want %0d 0", obs_q.size(), obs_busy_bad, ERASE ? 160 : 0); end
        checks++; if (pix_diff() !== 0 || obs_ndone !== 1) begin failures++; $display("FAIL empty_model: diff %0d done_pulses %0d want 0 1", pix_diff(), obs_ndone); end
    endtask

    task automatic test_random();
        logic [31:0] r, yv;
        for (int i = 0; i < 6; i++) begin
            r = $urandom & $urandom; yv = $urandom;
            build_exp(r, yv, 10, 4, 8, 0);
            run(1'b0, r, yv, -1, 1'b0, 1'b0);
            checks++; if (pix_diff() !== 0 || timing_err() !== 0) begin failures++; $display("FAIL random_%0d: diff %0d timing %0d red=%h yel=%h want 0 0", i, pix_diff(), timing_err(), r[9:0], yv[9:0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, y1;
        r1 = $urandom | 32'h1; y1 = $urandom;
        chain_red = $urandom | 32'h200; chain_yel = $urandom;
        build_exp(r1, y1, 10, 4, 8, 0);
        run(1'b0, r1, y1, -1, 1'b0, 1'b1);
        checks++; if (pix_diff() !== 0 || timing_err() !== 0) begin failures++; $display("FAIL b2b_first: diff %0d timing %0d want 0 0", pix_diff(), timing_err()); end
        build_exp(chain_red, chain_yel, 10, 4, 8, 0);
        run(1'b0, 32'd0, 32'd0, -1, 1'b1, 1'b0);
        checks++; if (pix_diff() !== 0 || timing_err() !== 0) begin failures++; $display("FAIL b2b_second: diff %0d timing %0d first_c %0d want 0 0 1", pix_diff(), timing_err(), obs_first); end
    endtask

    task automatic test_mid_start();
        logic [31:0] r, yv;
        r = $urandom | 32'h201; yv = $urandom;
        build_exp(r, yv, 10, 4, 8, 0);
        run(1'b0, r, yv, 10, 1'b0, 1'b0);
        checks++; if (pix_diff() !== 0 || timing_err() !== 0) begin failures++; $display("FAIL mid_start: diff %0d timing %0d count %0d want 0 0 %0d", pix_diff(), timing_err(), obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int late_done;
        logic [31:0] r, yv;
        late_done = 0;
        @(negedge clk); drive(1'b0, 32'h3FF, 32'd0, 1'b1);
        @(negedge clk); drive(1'b0, 32'h3FF, 32'd0, 1'b0);
        repeat (12) @(negedge clk);
        checks++; if (a_plot !== 1'b1) begin failures++; $display("FAIL reset_mid_active: plot %b want 1", a_plot); end
        resetn = 1'b0;
        #1;
        checks++; if ({a_x, a_y, a_col, a_plot, a_busy, a_done} !== '0) begin failures++; $display("FAIL reset_mid_clear: x=%0d y=%0d col=%b p/b/d=%b want all 0", a_x, a_y, a_col, {a_plot, a_busy, a_done}); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (a_done || a_plot || a_busy) late_done++;
        end
        checks++; if (late_done !== 0) begin failures++; $display("FAIL reset_mid_quiet: %0d active cycles after reset want 0", late_done); end
        r = $urandom | 32'h1; yv = $urandom;
        build_exp(r, yv, 10, 4, 8, 0);
        run(1'b0, r, yv, -1, 1'b0, 1'b0);
        checks++; if (pix_diff() !== 0 || timing_err() !== 0) begin failures++; $display("FAIL reset_mid_restart: diff %0d timing %0d want 0 0", pix_diff(), timing_err()); end
    endtask

    task automatic test_wide();
        int max_x;
        logic [31:0] r, yv;
        max_x = -1;
        build_exp(32'h5, 32'hA, 4, 8, 10, 100);
        run(1'b1, 32'h5, 32'hA, -1, 1'b0, 1'b0);
        foreach (obs_q[i]) if (int'(obs_q[i].x) > max_x) max_x = int'(obs_q[i].x);
        checks++; if (obs_q.size() !== 256) begin failures++; $display("FAIL wide_count: got %0d want 256", obs_q.size()); end
        checks++; if (max_x !== 137) begin failures++; $display("FAIL wide_max_x: got %0d want 137", max_x); end
        checks++; if (pix_diff() !== 0 || timing_err() !== 0) begin failures++; $display("FAIL wide_model: diff %0d timing %0d want 0 0", pix_diff(), timing_err()); end
        for (int i = 0; i < 3; i++) begin
            r = $urandom & $urandom; yv = $urandom & $urandom;
            build_exp(r, yv, 4, 8, 10, 100);
            run(1'b1, r, yv, -1, 1'b0, 1'b0);
            checks++; if (pix_diff() !== 0 || timing_err() !== 0) begin failures++; $display("FAIL wide_random_%0d: diff %0d timing %0d want 0 0", i, pix_diff(), timing_err()); end
        end
    endtask

    initial begin
        resetn = 1'b0;
        a_start = 1'b0; a_red = '0; a_yel = '0;
        b_start = 1'b0; b_red = '0; b_yel = '0;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        @(negedge clk);
        test_lane_pattern();
        test_priority();
        test_empty();
        test_random();
        test_back_to_back();
        test_mid_start();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
